slave_mode_controller: RTL and testbench

- Parametrised next-generation trigger/slave-mode block for the general-purpose timer.
- Inputs: N internal triggers, filtered timer inputs and an external trigger (ETR).
- Outputs: registered count-enable, direction, reset and start strobes for the time-base counter.
- Adds ETR sync/prescale/filter, quadrature encoder direction/error, reset/gated/trigger modes, and external clock mode 2 (ECE) as clock-enable pulses, not derived clocks.

---
 rtl/slave_mode_controller.sv | 204 ++++++++++++++++++++
 tb/tb_slave_mode_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_mode_controller.sv
// Trigger / slave-mode controller: turns triggers, encoder inputs and ETR into count-enable, direction and strobes for the time-base counter.
// Latency: all outputs registered, one cycle after the sampled event; ETR adds 2 sync stages before the filter register (3 cycles etr_i -> etrf_o when unfiltered).
// Backpressure: none; free-running per-cycle strobes, the counter consumes them every cycle.
module slave_mode_controller #(
  parameter int ITR_NUM = 4,
  parameter int ETPS_W  = 2,
  parameter int ETF_W   = 4,
  parameter int TS_W    = $clog2(ITR_NUM + 4)
) (
  input  logic               clk_i,
  input  logic               aresetn_i,
  input  logic [ITR_NUM-1:0] itr_i,
  input  logic [TS_W-1:0]    ts_i,
  input  logic [2:0]         sms_i,
  input  logic               cen_i,
  input  logic               ece_i,
  input  logic               etr_i,
  input  logic               etp_i,
  input  logic [ETPS_W-1:0]  etps_i,
  input  logic [ETF_W-1:0]   etf_i,
  input  logic               ti1fp1_i,
  input  logic               ti2fp2_i,
  input  logic               ti1_ed_i,
  output logic               cnt_en_o,
  output logic               cnt_dir_o,
  output logic               cnt_rst_o,
  output logic               cen_set_o,
  output logic               trg_o,
  output logic               enc_err_o,
  output logic               etrf_o
);

  // Wide enough that bit [etps_i-1] exists for every legal select value.
  localparam int PSC_W = (1 << ETPS_W) - 1;

  logic             etr_s1_q, etr_s2_q;
  logic             etr_pol;
  logic             etr_pol_q;
  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic             psc_out;
  logic [ETF_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             etrf_q, etrf_d;
  logic             trgi;
  logic             trgi_prev_q, etrf_prev_q, ti1_prev_q, ti2_prev_q;
  logic             trg_rise, etrf_rise, ti1_edge, ti2_edge;
  logic             clk_gate;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_dir_q, cnt_dir_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic             cen_set_q, cen_set_d;
  logic             trg_q, trg_d;
  logic             enc_err_q, enc_err_d;

  assign etr_pol = etr_s2_q ^ etp_i;

  // Prescaler: counts rising edges of the polarised ETR level; the selected bit is a 1/2^etps square wave.
  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (etr_pol && !etr_pol_q) psc_cnt_d = psc_cnt_q + PSC_W'(1);
    psc_out = etr_pol;
    for (int k = 1; k <= PSC_W; k++) begin
      if (int'(etps_i) == k) psc_out = psc_cnt_q[k-1];
    end
  end

  // Filter: output follows input only after etf_i consecutive differing samples; any glitch restarts.
  always_comb begin
    etrf_d    = etrf_q;
    flt_cnt_d = '0;
    if (etf_i == '0) begin
      etrf_d = psc_out;
    end else if (psc_out != etrf_q) begin
      if (flt_cnt_q == etf_i - ETF_W'(1)) etrf_d = psc_out;
      else flt_cnt_d = flt_cnt_q + ETF_W'(1);
    end
  end

  // Trigger input mux; unused select codes give a constant 0.
  always_comb begin
    trgi = 1'b0;
    for (int k = 0; k < ITR_NUM; k++) begin
      if (int'(ts_i) == k) trgi = itr_i[k];
    end
    if (int'(ts_i) == ITR_NUM)     trgi = ti1_ed_i;
    if (int'(ts_i) == ITR_NUM + 1) trgi = ti1fp1_i;
    if (int'(ts_i) == ITR_NUM + 2) trgi = ti2fp2_i;
    if (int'(ts_i) == ITR_NUM + 3) trgi = etrf_q;
  end

  // Edge detectors run in every mode so switching sms_i never manufactures an edge.
  assign trg_rise  = trgi & ~trgi_prev_q;
  assign etrf_rise = etrf_q & ~etrf_prev_q;
  assign ti1_edge  = ti1fp1_i ^ ti1_prev_q;
  assign ti2_edge  = ti2fp2_i ^ ti2_prev_q;
  assign clk_gate  = ece_i ? etrf_rise : 1'b1;

  // Slave-mode decode into next-cycle output strobes.
  always_comb begin
    cnt_en_d  = 1'b0;
    cnt_dir_d = 1'b0;
    cnt_rst_d = 1'b0;
    cen_set_d = 1'b0;
    trg_d     = 1'b0;
    enc_err_d = 1'b0;
    case (sms_i)
      3'b000: begin
        cnt_en_d = cen_i & clk_gate;
        trg_d    = trg_rise;
      end
      3'b001, 3'b010, 3'b011: begin
        cnt_dir_d = cnt_dir_q;
        if (sms_i == 3'b011 && ti1_edge && ti2_edge) begin
          enc_err_d = 1'b1;
        end else if (sms_i[0] && ti1_edge) begin
          cnt_en_d = cen_i;
          if (cen_i) cnt_dir_d = ~(ti1fp1_i ^ ti2fp2_i);
        end else if (sms_i[1] && ti2_edge) begin
          cnt_en_d = cen_i;
          if (cen_i) cnt_dir_d = ti1fp1_i ^ ti2fp2_i;
        end
      end
      3'b100: begin
        cnt_en_d  = cen_i & clk_gate;
        cnt_rst_d = trg_rise;
        trg_d     = trg_rise;
      end
      3'b101: begin
        cnt_en_d = cen_i & trgi & clk_gate;
        trg_d    = trg_rise;
      end
      3'b110: begin
        cnt_en_d  = cen_i & clk_gate;
        cen_set_d = trg_rise & ~cen_i;
        trg_d     = trg_rise;
      end
      default: begin
        cnt_en_d = cen_i & trg_rise;
        trg_d    = trg_rise;
      end
    endcase
  end

  // ETR conditioning state: synchroniser, prescaler, filter.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      etr_s1_q  <= 1'b0;
      etr_s2_q  <= 1'b0;
      etr_pol_q <= 1'b0;
      psc_cnt_q <= '0;
      flt_cnt_q <= '0;
      etrf_q    <= 1'b0;
    end else begin
      etr_s1_q  <= etr_i;
      etr_s2_q  <= etr_s1_q;
      etr_pol_q <= etr_pol;
      psc_cnt_q <= psc_cnt_d;
      flt_cnt_q <= flt_cnt_d;
      etrf_q    <= etrf_d;
    end
  end

  // Previous-sample registers for the edge detectors.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      trgi_prev_q <= 1'b0;
      etrf_prev_q <= 1'b0;
      ti1_prev_q  <= 1'b0;
      ti2_prev_q  <= 1'b0;
    end else begin
      trgi_prev_q <= trgi;
      etrf_prev_q <= etrf_q;
      ti1_prev_q  <= ti1fp1_i;
      ti2_prev_q  <= ti2fp2_i;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_en_q  <= 1'b0;
      cnt_dir_q <= 1'b0;
      cnt_rst_q <= 1'b0;
      cen_set_q <= 1'b0;
      trg_q     <= 1'b0;
      enc_err_q <= 1'b0;
    end else begin
      cnt_en_q  <= cnt_en_d;
      cnt_dir_q <= cnt_dir_d;
      cnt_rst_q <= cnt_rst_d;
      cen_set_q <= cen_set_d;
      trg_q     <= trg_d;
      enc_err_q <= enc_err_d;
    end
  end

  assign cnt_en_o  = cnt_en_q;
  assign cnt_dir_o = cnt_dir_q;
  assign cnt_rst_o = cnt_rst_q;
  assign cen_set_o = cen_set_q;
  assign trg_o     = trg_q;
  assign enc_err_o = enc_err_q;
  assign etrf_o    = etrf_q;

endmodule

// File: tb/tb_slave_mode_controller.sv
// Bench for slave_mode_controller: vector table through a scoreboard queue, then ETR and reset sequences.
module tb_slave_mode_controller;

  localparam int ITR_NUM = 4;
  localparam int TS_W    = 3;

  logic             clk_i = 1'b0;
  logic             aresetn_i;
  logic [ITR_NUM-1:0] itr_i;
  logic [TS_W-1:0]  ts_i;
  logic [2:0]       sms_i;
  logic             cen_i, ece_i, etr_i, etp_i;
  logic [1:0]       etps_i;
  logic [3:0]       etf_i;
  logic             ti1fp1_i, ti2fp2_i, ti1_ed_i;
  logic             cnt_en_o, cnt_dir_o, cnt_rst_o, cen_set_o, trg_o, enc_err_o, etrf_o;
  logic [5:0]       outs;

  assign outs = {cnt_en_o, cnt_dir_o, cnt_rst_o, cen_set_o, trg_o, enc_err_o};

  always #5 clk_i = ~clk_i;

  slave_mode_controller #(.ITR_NUM(ITR_NUM), .ETPS_W(2), .ETF_W(4), .TS_W(TS_W)) dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i), .itr_i(itr_i), .ts_i(ts_i), .sms_i(sms_i),
    .cen_i(cen_i), .ece_i(ece_i), .etr_i(etr_i), .etp_i(etp_i), .etps_i(etps_i),
    .etf_i(etf_i), .ti1fp1_i(ti1fp1_i), .ti2fp2_i(ti2fp2_i), .ti1_ed_i(ti1_ed_i),
    .cnt_en_o(cnt_en_o), .cnt_dir_o(cnt_dir_o), .cnt_rst_o(cnt_rst_o),
    .cen_set_o(cen_set_o), .trg_o(trg_o), .enc_err_o(enc_err_o), .etrf_o(etrf_o)
  );

  // ex = {cnt_en, cnt_dir, cnt_rst, cen_set, trg, enc_err}; ti = {ti1fp1, ti2fp2}
  typedef struct {
    string      name;
    logic [2:0] sms;
    logic       cen;
    logic [2:0] ts;
    logic [3:0] itr;
    logic [1:0] ti;
    logic       ted;
    logic [5:0] ex;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_en, n_trg, n_rise, n_hi;
  logic etrf_prev;

  function automatic vec_t mk(input string n, input logic [2:0] sms, input logic cen,
                              input logic [2:0] ts, input logic [3:0] itr,
                              input logic [1:0] ti, input logic ted, input logic [5:0] ex);
    vec_t v;
    v.name = n; v.sms = sms; v.cen = cen; v.ts = ts; v.itr = itr;
    v.ti = ti; v.ted = ted; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clr_cnt();
    n_en = 0; n_trg = 0; n_rise = 0; n_hi = 0;
    etrf_prev = etrf_o;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      if (cnt_en_o) n_en++;
      if (trg_o) n_trg++;
      if (etrf_o && !etrf_prev) n_rise++;
      if (etrf_o) n_hi++;
      etrf_prev = etrf_o;
    end
  endtask

  task automatic etr_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      etr_i = 1'b1; cyc(3);
      etr_i = 1'b0; cyc(3);
    end
  endtask

  initial begin
    vec_t v, e;
    aresetn_i = 1'b0; itr_i = '0; ts_i = '0; sms_i = 3'b000; cen_i = 1'b1; ece_i = 1'b0;
    etr_i = 1'b0; etp_i = 1'b0; etps_i = '0; etf_i = '0;
    ti1fp1_i = 1'b0; ti2fp2_i = 1'b0; ti1_ed_i = 1'b0;
    clr_cnt();

    // Mode 000 / encoder / reset / gated / trigger / ECM1 vectors, ETR idle.
    vecs.push_back(mk("m0_en",       3'd0, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("m0_cen0",     3'd0, 0, 3'd0, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("m0_trg",      3'd0, 1, 3'd0, 4'b0001, 2'b00, 0, 6'b100010));
    vecs.push_back(mk("m0_hold",     3'd0, 1, 3'd0, 4'b0001, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("m0_fall",     3'd0, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("enc_idle",    3'd3, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("enc_fwd1",    3'd3, 1, 3'd0, 4'b0000, 2'b10, 0, 6'b100000));
    vecs.push_back(mk("enc_fwd2",    3'd3, 1, 3'd0, 4'b0000, 2'b11, 0, 6'b100000));
    vecs.push_back(mk("enc_fwd3",    3'd3, 1, 3'd0, 4'b0000, 2'b01, 0, 6'b100000));
    vecs.push_back(mk("enc_fwd4",    3'd3, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("enc_rev1",    3'd3, 1, 3'd0, 4'b0000, 2'b01, 0, 6'b110000));
    vecs.push_back(mk("enc_rev2",    3'd3, 1, 3'd0, 4'b0000, 2'b11, 0, 6'b110000));
    vecs.push_back(mk("enc_rev3",    3'd3, 1, 3'd0, 4'b0000, 2'b10, 0, 6'b110000));
    vecs.push_back(mk("enc_rev4",    3'd3, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b110000));
    vecs.push_back(mk("enc_dirhold", 3'd3, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b010000));
    vecs.push_back(mk("enc_err",     3'd3, 1, 3'd0, 4'b0000, 2'b11, 0, 6'b010001));
    vecs.push_back(mk("enc_err_clr", 3'd3, 1, 3'd0, 4'b0000, 2'b11, 0, 6'b010000));
    vecs.push_back(mk("ti1_fall_up", 3'd1, 1, 3'd0, 4'b0000, 2'b01, 0, 6'b100000));
    vecs.push_back(mk("ti1m_ign_a",  3'd1, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("ti1m_ign_b",  3'd1, 1, 3'd0, 4'b0000, 2'b01, 0, 6'b000000));
    vecs.push_back(mk("ti1_rise_dn", 3'd1, 1, 3'd0, 4'b0000, 2'b11, 0, 6'b110000));
    vecs.push_back(mk("ti2_fall_dn", 3'd2, 1, 3'd0, 4'b0000, 2'b10, 0, 6'b110000));
    vecs.push_back(mk("ti2m_ign_a",  3'd2, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b010000));
    vecs.push_back(mk("ti2m_ign_b",  3'd2, 1, 3'd0, 4'b0000, 2'b10, 0, 6'b010000));
    vecs.push_back(mk("ti2_rise_up", 3'd2, 1, 3'd0, 4'b0000, 2'b11, 0, 6'b100000));
    vecs.push_back(mk("m0_dir_zero", 3'd0, 1, 3'd0, 4'b0000, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("rst_idle",    3'd4, 1, 3'd5, 4'b0000, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("rst_pulse",   3'd4, 1, 3'd5, 4'b0000, 2'b10, 0, 6'b101010));
    vecs.push_back(mk("rst_hold",    3'd4, 1, 3'd5, 4'b0000, 2'b10, 0, 6'b100000));
    vecs.push_back(mk("rst_fall",    3'd4, 1, 3'd5, 4'b0000, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("gate_lo",     3'd5, 1, 3'd5, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("gate_rise",   3'd5, 1, 3'd5, 4'b0000, 2'b10, 0, 6'b100010));
    vecs.push_back(mk("gate_hi",     3'd5, 1, 3'd5, 4'b0000, 2'b10, 0, 6'b100000));
    vecs.push_back(mk("gate_cen0",   3'd5, 0, 3'd5, 4'b0000, 2'b10, 0, 6'b000000));
    vecs.push_back(mk("gate_off",    3'd5, 1, 3'd5, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("trgm_idle",   3'd6, 0, 3'd2, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("trgm_censet", 3'd6, 0, 3'd2, 4'b0100, 2'b00, 0, 6'b000110));
    vecs.push_back(mk("trgm_run",    3'd6, 1, 3'd2, 4'b0100, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("trgm_fall",   3'd6, 1, 3'd2, 4'b0000, 2'b00, 0, 6'b100000));
    vecs.push_back(mk("trgm_rise2",  3'd6, 1, 3'd2, 4'b0100, 2'b00, 0, 6'b100010));
    vecs.push_back(mk("ecm1_sw_hi",  3'd7, 1, 3'd2, 4'b0100, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("ecm1_lo",     3'd7, 1, 3'd2, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("ecm1_rise",   3'd7, 1, 3'd2, 4'b0100, 2'b00, 0, 6'b100010));
    vecs.push_back(mk("ecm1_hold",   3'd7, 1, 3'd2, 4'b0100, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("ecm1_c0_lo",  3'd7, 0, 3'd2, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("ecm1_c0_rise",3'd7, 0, 3'd2, 4'b0100, 2'b00, 0, 6'b000010));
    vecs.push_back(mk("ted_lo",      3'd7, 1, 3'd4, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("ted_rise",    3'd7, 1, 3'd4, 4'b0000, 2'b00, 1, 6'b100010));
    vecs.push_back(mk("ted_fall",    3'd7, 1, 3'd4, 4'b0000, 2'b00, 0, 6'b000000));
    vecs.push_back(mk("ti2sel_rise", 3'd0, 1, 3'd6, 4'b0000, 2'b01, 0, 6'b100010));
    vecs.push_back(mk("ti2sel_fall", 3'd0, 1, 3'd6, 4'b0000, 2'b00, 0, 6'b100000));

    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outs", {25'd0, outs, etrf_o}, 32'd0);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("first_after_reset", outs, 6'b100000);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      sms_i = v.sms; cen_i = v.cen; ts_i = v.ts; itr_i = v.itr;
      ti1fp1_i = v.ti[1]; ti2fp2_i = v.ti[0]; ti1_ed_i = v.ted;
      sb_q.push_back(v);
      @(posedge clk_i);
      #1;
      e = sb_q.pop_front();
      chk(e.name, outs, e.ex);
    end

    // ETR latency, unfiltered and unscaled.
    sms_i = 3'd0; cen_i = 1'b1; ece_i = 1'b0; ts_i = '0; itr_i = '0;
    ti1fp1_i = 1'b0; ti2fp2_i = 1'b0; ti1_ed_i = 1'b0;
    cyc(3);
    etr_i = 1'b1;
    cyc(2);
    chk("etr_lat2", etrf_o, 0);
    cyc(1);
    chk("etr_lat3", etrf_o, 1);
    etr_i = 1'b0;
    cyc(4);

    // Prescaler /4 over 8 ETR edges, with ECE clocking in mode 000.
    etps_i = 2'd2; ece_i = 1'b1;
    clr_cnt();
    etr_pulses(8);
    cyc(4);
    chk("psc_rises", n_rise, 2);
    chk("psc_high_cycles", n_hi, 24);
    chk("ece_pulses", n_en, 2);

    // Filter of 3 rejects a 2-cycle glitch, then accepts a held level at 5 cycles.
    etps_i = '0; ece_i = 1'b0;
    cyc(4);
    etf_i = 4'd3;
    clr_cnt();
    etr_i = 1'b1; cyc(2);
    etr_i = 1'b0; cyc(8);
    chk("flt_glitch_hi", n_hi, 0);
    etr_i = 1'b1;
    cyc(4);
    chk("flt_lat4", etrf_o, 0);
    cyc(1);
    chk("flt_lat5", etrf_o, 1);

    // Polarity inversion.
    etf_i = '0; etp_i = 1'b1;
    cyc(2);
    chk("etp_inv_hi_in", etrf_o, 0);
    etr_i = 1'b0;
    cyc(3);
    chk("etp_inv_lo_in", etrf_o, 1);
    etp_i = 1'b0;
    cyc(3);

    // ECM1 on ETRF with ece set: one enable per ETRF rise.
    sms_i = 3'd7; ts_i = 3'd7; ece_i = 1'b1;
    cyc(2);
    clr_cnt();
    etr_pulses(3);
    cyc(3);
    chk("ecm1_en", n_en, 3);
    chk("ecm1_trg", n_trg, 3);

    // Mode change while trgi is high must not create a pulse.
    etr_i = 1'b1;
    cyc(5);
    clr_cnt();
    sms_i = 3'd4; cyc(2);
    sms_i = 3'd7; cyc(3);
    chk("modechg_en", n_en, 0);
    chk("modechg_trg", n_trg, 0);

    // Asynchronous reset mid-run, then a clean release.
    sms_i = 3'd4; ece_i = 1'b0;
    cyc(2);
    chk("pre_rst_en", outs, 6'b100000);
    #2;
    aresetn_i = 1'b0;
    #1;
    chk("async_rst", {25'd0, outs, etrf_o}, 32'd0);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("release_first", outs, 6'b100000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
